// File: rtl/camera_poll_pkg.sv
// camera_poll_pkg
//   Shared definitions for the camera input poller slice:
//   - poll_state_t : poller FSM state encoding (IDLE, REQ, WAIT)
//   - CAM_PIO_ADDR : word address of the camera PIO data register
//   - AVM_DATA_W   : width of the Avalon-MM readdata bus
package camera_poll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } poll_state_t;

    localparam logic [1:0]  CAM_PIO_ADDR = 2'd0;
    localparam int unsigned AVM_DATA_W   = 32;

endpackage

// File: rtl/camera_poll_fifo.sv
// camera_poll_fifo
//   Synchronous show-ahead FIFO. The head entry is visible on pop_data
//   whenever the FIFO is not empty; a pop exposes the next entry on the
//   following cycle. A push into a full FIFO is accepted only when a pop
//   happens in the same cycle.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, push_data   write request and data
//   pop               read request (ignored while empty)
//   pop_data          head of the FIFO (0 while empty)
//   full, empty       occupancy flags, derived from the registered level
//   level             current occupancy, 0..DEPTH
// Parameters:
//   WIDTH  entry width
//   DEPTH  number of entries (power of 2, at least 2)
module camera_poll_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Gated so the output reads 0 after reset instead of stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/camera_input_poller.sv
// camera_input_poller
//   Avalon-MM read initiator that periodically polls the camera input PIO
//   (register 0) and turns the polled values into a buffered valid/ready
//   sample stream.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             polling allowed while high
//   clear_ovf          one-cycle pulse clearing overflow
//   avm_address        always CAM_PIO_ADDR
//   avm_read           read request, driven from the registered REQ state
//   avm_waitrequest    slave stall
//   avm_readdata       slave read data; only [DATA_WIDTH-1:0] is used
//   sample_data        FIFO head (show-ahead)
//   sample_valid       FIFO not empty
//   sample_ready       consumer accepts the head sample
//   fifo_level         FIFO occupancy
//   overflow           sticky, set when a sample is dropped on a full FIFO
// Configuration:
//   CAMERA_POLL_CHANGE_ONLY_EN - when defined, a captured value is pushed only
//   if it differs from the previously captured value.
module camera_input_poller
    import camera_poll_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned POLL_DIV     = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear_ovf,
    output logic [1:0]                    avm_address,
    output logic                          avm_read,
    input  logic                          avm_waitrequest,
    input  logic [AVM_DATA_W-1:0]         avm_readdata,
    output logic [DATA_WIDTH-1:0]         sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned PCNT_W = $clog2(POLL_DIV + 1);
    localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);

    poll_state_t        state;
    poll_state_t        state_nxt;
    logic [PCNT_W-1:0]  poll_cnt;
    logic [PCNT_W-1:0]  poll_cnt_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_cnt_nxt;
    logic               capture;

    logic [DATA_WIDTH-1:0] cap_data;
    logic                  push_req;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;
    logic                  unused_readdata_hi;

    assign cap_data           = avm_readdata[DATA_WIDTH-1:0];
    assign unused_readdata_hi = ^avm_readdata[AVM_DATA_W-1:DATA_WIDTH];

    // ------------------------------------------------------------------
    // Poll FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            poll_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= poll_cnt_nxt;
            lat_cnt  <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        poll_cnt_nxt = poll_cnt;
        lat_cnt_nxt  = lat_cnt;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (!enable) begin
                    poll_cnt_nxt = '0;
                end else if (poll_cnt == PCNT_W'(POLL_DIV - 1)) begin
                    poll_cnt_nxt = '0;
                    state_nxt    = REQ;
                end else begin
                    poll_cnt_nxt = poll_cnt + 1'b1;
                end
            end
            // A started read always completes, even if enable drops.
            REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt   = WAIT;
                    lat_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                    capture     = 1'b1;
                    lat_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign avm_read    = (state == REQ);
    assign avm_address = CAM_PIO_ADDR;

    // ------------------------------------------------------------------
    // Push qualification
    // ------------------------------------------------------------------
`ifdef CAMERA_POLL_CHANGE_ONLY_EN
    logic [DATA_WIDTH-1:0] last_val;

    // Tracks every capture, including ones dropped on a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_val <= '0;
        end else if (capture) begin
            last_val <= cap_data;
        end
    end

    assign push_req = capture && (cap_data != last_val);
`else
    assign push_req = capture;
`endif

    // ------------------------------------------------------------------
    // Sample buffer and overflow flag
    // ------------------------------------------------------------------
    assign pop          = sample_valid && sample_ready;
    assign sample_valid = !fifo_empty;
    assign drop         = push_req && fifo_full && !pop;

    camera_poll_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (cap_data),
        .pop       (pop),
        .pop_data  (sample_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/camera_input_poller.md
# camera_input_poller

Avalon-MM read initiator that periodically polls the 12-bit camera input PIO slave (register 0, 32-bit readdata, registered read data) and turns the polled values into a buffered valid/ready sample stream. It sits between the camera input PIO and downstream pixel logic, so those consumers do not need a Nios II software polling loop. It has one clock and a small show-ahead FIFO.

## Interface
- DATA_WIDTH, 12, width of the captured sample; taken from readdata[DATA_WIDTH-1:0].
- POLL_DIV, 16, number of idle cycles between polls (at least 1).
- READ_LATENCY, 1, number of cycles from read acceptance to valid readdata (at least 1).
- FIFO_DEPTH, 8, number of sample buffer entries (power of 2).
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling is allowed while high.
- clear_ovf  in  1  one-cycle pulse that clears `overflow`.
- avm_address  out  2  always 0.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; tie to 0 when the slave has none.
- avm_readdata  in  32  slave read data.
- sample_data  out  DATA_WIDTH  head of the FIFO.
- sample_valid  out  1  FIFO is not empty.
- sample_ready  in  1  consumer accepts the sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a sample is dropped.

## Operation
- FSM states and transitions:
  - IDLE: if enable is high, poll_cnt increments. When poll_cnt reaches POLL_DIV-1, poll_cnt clears and the FSM goes to REQ. If enable is low, poll_cnt holds at 0.
  - REQ: avm_read is 1. The FSM stays in REQ while avm_waitrequest is 1. When the read is accepted, it goes to WAIT and lat_cnt is set to 0.
  - WAIT: lat_cnt increments. When lat_cnt reaches READ_LATENCY-1, the FSM captures avm_readdata[DATA_WIDTH-1:0], pushes it, and returns to IDLE.
- Push and pop rules:
  - A pop occurs on sample_valid && sample_ready.
  - A push while the FIFO is full is dropped and sets overflow, unless a pop happens in the same cycle. In that case the push is accepted and the level is unchanged.
  - If clear_ovf and a new drop occur in the same cycle, overflow stays 1.
- Enable deasserted in REQ or WAIT: the current transaction completes and its sample is pushed. The FSM then holds in IDLE.
- avm_readdata[31:DATA_WIDTH] is ignored.
- avm_address is constant 0.
- Reset mid-transaction: every output drops to its reset value at once, the FSM goes to IDLE, and FIFO contents are discarded.
- Reset values:
  - avm_read=0, avm_address=0.
  - sample_valid=0, sample_data=0.
  - fifo_level=0, overflow=0.
  - FSM=IDLE, poll_cnt=0, lat_cnt=0.
  - The last-value register is 0.

## Timing
- avm_read is driven directly from the registered state REQ and has no combinational path from inputs.
- Poll period with no wait states is POLL_DIV + 1 + READ_LATENCY cycles (18 with the defaults). Each wait-state cycle adds one cycle.
- Capture to sample_valid is 1 cycle; sample_valid rises on the edge after the push.
- sample_data is valid in the same cycle as sample_valid (show-ahead). A pop exposes the next entry on the following cycle.
- The FIFO has no combinational path from sample_ready to sample_valid.

## Configuration
- CAMERA_POLL_CHANGE_ONLY_EN:
  - When defined: a captured value is pushed only if it differs from the last captured value. The last-value register updates on every capture, including dropped ones.
  - When not defined: every poll pushes a sample, and the last-value register is not synthesized.

## Structure
- Package camera_poll_pkg holds:
  - the state enum poll_state_t {IDLE, REQ, WAIT};
  - the localparam CAM_PIO_ADDR = 2'd0;
  - the readdata width constant 32.
- One sub-module, camera_poll_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level, and asynchronous active-low reset.

## Test plan
- Reset release with enable=1, avm_waitrequest=0, and the slave returning 0x0000_0ABC: the first avm_read appears in cycle 16 after reset. sample_valid=1 with sample_data=0xABC in cycle 18. Subsequent reads occur every 18 cycles.
- Hold avm_waitrequest=1 for 3 cycles during REQ: avm_read stays high for 4 cycles, and the period stretches to 21 cycles.
- Hold sample_ready=0 with the default configuration: after 8 polls, fifo_level=8. The 9th poll sets overflow=1 while the level stays 8. A clear_ovf pulse returns overflow to 0.
- With a full FIFO, assert sample_ready in the capture cycle: no overflow, fifo_level stays 8, and the newest value sits at the tail.
- Slave returns 0xFFFF_F123: sample_data=0x123. With CAMERA_POLL_CHANGE_ONLY_EN defined and a constant 0x123 over 5 polls, exactly 1 sample is pushed.
- Assert reset_n=0 while in WAIT with 3 entries queued: avm_read=0, sample_valid=0, and fifo_level=0 immediately. After release, the first read occurs again in cycle 16.
